// File: rtl/unsdoubletoint_if.sv
// Handshake bundle for the double -> unsigned int converter.
//
// Handshake: en is a level enable driven by the master. While en is high the
// converter samples input_a at the start of every conversion and, when
// the result is ready, updates output_z/invalid and raises complete for
// exactly one clock. There is no back-pressure: the master must read the
// result in the cycle complete is high. Dropping en clears the outputs and
// returns the converter to idle on the next clock edge.
interface unsdoubletoint_if;
  logic        en;
  logic [63:0] input_a;
  logic [31:0] output_z;
  logic        complete;
  logic        invalid;

  modport master (
    output en,
    output input_a,
    input  output_z,
    input  complete,
    input  invalid
  );

  modport slave (
    input  en,
    input  input_a,
    output output_z,
    output complete,
    output invalid
  );
endinterface

// File: rtl/unsdoubletoint.sv
// IEEE-754 double to 32-bit unsigned integer converter.
// Truncates toward zero and saturates out-of-range inputs. The mantissa is
// right-shifted one bit per clock, so latency depends on the exponent.
module unsdoubletoint (
  input  logic              clk,
  input  logic              rst,
  unsdoubletoint_if.slave   bus,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    UNPACK = 3'd1,
    SHIFT  = 3'd2,
    PACK   = 3'd3,
    PUT_Z  = 3'd4
  } state_t;

  state_t      state_q;
  logic [63:0] a_q;
  logic [52:0] m_q;
  logic [5:0]  n_q;
  logic [31:0] r_q;
  logic        inv_q;
  logic [31:0] z_q;
  logic        inv_z_q;
  logic [31:0] output_z_q;
  logic        complete_q;
  logic        invalid_q;

  logic        sign_w;
  logic [10:0] exp_w;
  logic [51:0] frac_w;
  logic [11:0] e_w;
  logic [5:0]  n_w;
  logic        e_neg_w;
  logic        e_big_w;

  // Field decode of the captured operand; e_w is the unbiased exponent.
  always_comb begin
    sign_w  = a_q[63];
    exp_w   = a_q[62:52];
    frac_w  = a_q[51:0];
    e_w     = {1'b0, exp_w} - 12'd1023;
    e_neg_w = e_w[11];
    e_big_w = !e_w[11] && (e_w > 12'd31);
    // Only meaningful for 0 <= e <= 31, where it yields 21..52.
    n_w     = 6'd52 - e_w[5:0];
  end

  // Conversion FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= GET_A;
      a_q        <= '0;
      m_q        <= '0;
      n_q        <= '0;
      r_q        <= '0;
      inv_q      <= 1'b0;
      z_q        <= '0;
      inv_z_q    <= 1'b0;
      output_z_q <= '0;
      complete_q <= 1'b0;
      invalid_q  <= 1'b0;
    end else if (!bus.en) begin
      state_q    <= GET_A;
      output_z_q <= '0;
      complete_q <= 1'b0;
      invalid_q  <= 1'b0;
    end else begin
      case (state_q)
        GET_A: begin
          a_q        <= bus.input_a;
          complete_q <= 1'b0;
          state_q    <= UNPACK;
        end
        UNPACK: begin
          m_q     <= {1'b1, frac_w};
          n_q     <= n_w;
          state_q <= PACK;
          if (exp_w == 11'h7FF && frac_w != '0) begin
            r_q   <= '0;
            inv_q <= 1'b1;
          end else if (exp_w == 11'h7FF) begin
            r_q   <= sign_w ? 32'h0 : 32'hFFFF_FFFF;
            inv_q <= 1'b1;
          end else if (exp_w == 11'h000) begin
            r_q   <= '0;
            inv_q <= 1'b0;
          end else if (e_neg_w) begin
            r_q   <= '0;
            inv_q <= 1'b0;
          end else if (sign_w) begin
            r_q   <= '0;
            inv_q <= 1'b1;
          end else if (e_big_w) begin
            r_q   <= 32'hFFFF_FFFF;
            inv_q <= 1'b1;
          end else begin
            inv_q   <= 1'b0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          m_q <= m_q >> 1;
          n_q <= n_q - 6'd1;
          // Last of the n shifts: take the result from the shifted value.
          if (n_q == 6'd1) begin
            r_q     <= m_q[32:1];
            state_q <= PACK;
          end
        end
        PACK: begin
          z_q     <= r_q;
          inv_z_q <= inv_q;
          state_q <= PUT_Z;
        end
        PUT_Z: begin
          output_z_q <= z_q;
          invalid_q  <= inv_z_q;
          complete_q <= 1'b1;
          state_q    <= GET_A;
        end
        default: state_q <= GET_A;
      endcase
    end
  end

  assign bus.output_z = output_z_q;
  assign bus.complete = complete_q;
  assign bus.invalid  = invalid_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_unsdoubletoint.sv
// Directed testbench for the double -> unsigned int converter.
module tb_unsdoubletoint;

  logic       clk;
  logic       rst;
  logic [2:0] state_o;
  int         total;
  int         bad;
  logic [32:0] exp_q[$];

  unsdoubletoint_if bus ();

  unsdoubletoint dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_o)
  );

  typedef struct {
    logic [63:0] a;
    logic [31:0] z;
    logic        inv;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one operand and wait for its result; caller is positioned before
  // the capture edge with the DUT in GET_A.
  task automatic run_vec(input logic [63:0] a, input logic [31:0] z,
                         input logic inv, input int lat);
    int cnt;
    bit got;
    logic [32:0] e;
    bus.input_a = a;
    exp_q.push_back({inv, z});
    @(posedge clk); #1;
    check("pulse_low", {63'd0, bus.complete}, 64'd0);
    // Operand must be ignored after the capture edge.
    bus.input_a = {$urandom, $urandom};
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
      if (bus.complete) got = 1'b1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL timeout: no complete for a=%0h after %0d edges", a, cnt);
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      check("output_z", {32'd0, bus.output_z}, {32'd0, e[31:0]});
      check("invalid", {63'd0, bus.invalid}, {63'd0, e[32]});
      check("latency", 64'(cnt), 64'(lat));
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    vecs[0]  = '{64'h3FF0000000000000, 32'h00000001, 1'b0, 55}; // 1.0
    vecs[1]  = '{64'h400E000000000000, 32'h00000003, 1'b0, 54}; // 3.75
    vecs[2]  = '{64'h41EFFFFFFFE00000, 32'hFFFFFFFF, 1'b0, 24}; // 2^32-1
    vecs[3]  = '{64'h41F0000000000000, 32'hFFFFFFFF, 1'b1, 3};  // 2^32
    vecs[4]  = '{64'h3FE0000000000000, 32'h00000000, 1'b0, 3};  // 0.5
    vecs[5]  = '{64'h8000000000000000, 32'h00000000, 1'b0, 3};  // -0.0
    vecs[6]  = '{64'hC000000000000000, 32'h00000000, 1'b1, 3};  // -2.0
    vecs[7]  = '{64'h7FF8000000000000, 32'h00000000, 1'b1, 3};  // NaN
    vecs[8]  = '{64'h4059000000000000, 32'h00000064, 1'b0, 49}; // 100.0
    vecs[9]  = '{64'hFFF0000000000000, 32'h00000000, 1'b1, 3};  // -Inf
    vecs[10] = '{64'h7FF0000000000000, 32'hFFFFFFFF, 1'b1, 3};  // +Inf

    rst = 1'b1;
    bus.en = 1'b1;
    bus.input_a = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_output_z", {32'd0, bus.output_z}, 64'd0);
    check("rst_complete", {63'd0, bus.complete}, 64'd0);
    check("rst_invalid", {63'd0, bus.invalid}, 64'd0);
    check("rst_state", {61'd0, state_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven, back-to-back conversions
    for (int i = 0; i < 11; i++)
      run_vec(vecs[i].a, vecs[i].z, vecs[i].inv, vecs[i].lat);

    // Asynchronous reset during SHIFT of 1.0 (outputs hold 0xFFFFFFFF/1)
    bus.input_a = 64'h3FF0000000000000;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_output_z", {32'd0, bus.output_z}, 64'd0);
    check("arst_invalid", {63'd0, bus.invalid}, 64'd0);
    check("arst_complete", {63'd0, bus.complete}, 64'd0);
    check("arst_state", {61'd0, state_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(64'h400E000000000000, 32'h00000003, 1'b0, 54);

    // Drop en during SHIFT (output_z holds 3)
    bus.input_a = 64'h3FF0000000000000;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.en = 1'b0;
    @(posedge clk); #1;
    check("en0_output_z", {32'd0, bus.output_z}, 64'd0);
    check("en0_complete", {63'd0, bus.complete}, 64'd0);
    check("en0_invalid", {63'd0, bus.invalid}, 64'd0);
    check("en0_state", {61'd0, state_o}, 64'd0);
    @(negedge clk);
    bus.en = 1'b1;
    run_vec(64'h3FF0000000000000, 32'h00000001, 1'b0, 55);

    // Back-to-back: each complete must be a single-cycle pulse
    run_vec(64'h41F0000000000000, 32'hFFFFFFFF, 1'b1, 3);
    run_vec(64'h7FF8000000000000, 32'h00000000, 1'b1, 3);
    run_vec(64'h400E000000000000, 32'h00000003, 1'b0, 54);
    @(posedge clk); #1;
    check("final_pulse_low", {63'd0, bus.complete}, 64'd0);
    check("final_hold_z", {32'd0, bus.output_z}, 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
